// File: rtl/mips_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: operation codes and FSM states.
package mips_pkg;

   typedef enum logic [1:0] {
      OP_MULT  = 2'd0,
      OP_MULTU = 2'd1,
      OP_DIV   = 2'd2,
      OP_DIVU  = 2'd3
   } muldiv_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } muldiv_state_t;

endpackage

// File: rtl/hilo_muldiv_if.sv
// Core-to-muldiv bundle: launch request, MTHI/MTLO writes, and the HI/LO/busy/done view back.
interface hilo_muldiv_if #(parameter int WIDTH = 32);
   import mips_pkg::*;

   // start is a request sampled on a rising edge only while busy is low; there is no
   // ready back-pressure beyond busy, and done is a single-cycle completion strobe.
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] rs_data;
   logic [WIDTH-1:0] rt_data;
   logic             hi_write;
   logic             lo_write;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             busy;
   logic             done;

   modport master (
      output start, op, rs_data, rt_data, hi_write, lo_write,
      input  hi, lo, busy, done
   );

   modport slave (
      input  start, op, rs_data, rt_data, hi_write, lo_write,
      output hi, lo, busy, done
   );

endinterface

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: a shift-add multiply step or a restoring divide step
// over the 2*WIDTH accumulator {upper, lower}.
module muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic               is_div,
   input  logic [2*WIDTH-1:0] acc_in,
   input  logic [WIDTH-1:0]   operand,
   output logic [2*WIDTH-1:0] acc_out
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH+1:0] diff;
   logic             borrow;
   logic [WIDTH-1:0] rem_nx;
   logic             unused_diff;

   always_comb begin
      // Multiply: add the multiplicand into the upper half when the current LSB is set,
      // then shift the whole accumulator (carry included) right by one.
      sum    = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, operand} : '0);
      // Divide: remainder in the upper half, dividend/quotient bits in the lower half.
      rem_sh = {acc_in[2*WIDTH-1:WIDTH], acc_in[WIDTH-1]};
      diff   = {1'b0, rem_sh} - {2'b00, operand};
      borrow = diff[WIDTH+1];
      // Either branch leaves a remainder below the divisor, so WIDTH bits always suffice.
      rem_nx = borrow ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
      if (is_div) begin
         acc_out = {rem_nx, acc_in[WIDTH-2:0], ~borrow};
      end else begin
         acc_out = {sum, acc_in[WIDTH-1:1]};
      end
   end

   assign unused_diff = diff[WIDTH];

endmodule

// File: rtl/hilo_muldiv.sv
// HI/LO owner: iterative MULT/MULTU/DIV/DIVU with sign fix-up, plus MTHI/MTLO writes while idle.
module hilo_muldiv
   import mips_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   hilo_muldiv_if.slave  bus,
   output muldiv_state_t dbg_state
);

   localparam int CW = $clog2(WIDTH);

   muldiv_state_t      state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   a_raw_q, a_raw_d;
   logic               is_div_q, is_div_d;
   logic               neg_q, neg_d;
   logic               rneg_q, rneg_d;
   logic               dz_q, dz_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               done_q, done_d;

   muldiv_op_t         op_in;
   logic               signed_op;
   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [2*WIDTH-1:0] step_acc;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .is_div  (is_div_q),
      .acc_in  (acc_q),
      .operand (b_q),
      .acc_out (step_acc)
   );

   always_comb begin
      op_in     = muldiv_op_t'(bus.op);
      signed_op = (op_in == OP_MULT) || (op_in == OP_DIV);
      a_neg     = signed_op && bus.rs_data[WIDTH-1];
      b_neg     = signed_op && bus.rt_data[WIDTH-1];
      a_mag     = a_neg ? -bus.rs_data : bus.rs_data;
      b_mag     = b_neg ? -bus.rt_data : bus.rt_data;

      prod_fix  = neg_q  ? -acc_q : acc_q;
      quo_fix   = neg_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      rem_fix   = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      b_d      = b_q;
      a_raw_d  = a_raw_q;
      is_div_d = is_div_q;
      neg_d    = neg_q;
      rneg_d   = rneg_q;
      dz_d     = dz_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               // A launch drops any MTHI/MTLO presented in the same cycle.
               state_d  = RUN;
               cnt_d    = '0;
               acc_d    = {{WIDTH{1'b0}}, a_mag};
               b_d      = b_mag;
               a_raw_d  = bus.rs_data;
               is_div_d = (op_in == OP_DIV) || (op_in == OP_DIVU);
               neg_d    = a_neg ^ b_neg;
               rneg_d   = a_neg;
               dz_d     = ((op_in == OP_DIV) || (op_in == OP_DIVU)) && (bus.rt_data == '0);
            end else begin
               if (bus.hi_write) hi_d = bus.rs_data;
               if (bus.lo_write) lo_d = bus.rs_data;
            end
         end
         RUN: begin
            acc_d = step_acc;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH-1)) state_d = FIX;
         end
         FIX: begin
            if (!is_div_q) begin
               hi_d = prod_fix[2*WIDTH-1:WIDTH];
               lo_d = prod_fix[WIDTH-1:0];
            end else if (dz_q) begin
               // Divide by zero returns the dividend as written, not its magnitude.
               hi_d = a_raw_q;
               lo_d = '1;
            end else begin
               hi_d = rem_fix;
               lo_d = quo_fix;
            end
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         b_q      <= '0;
         a_raw_q  <= '0;
         is_div_q <= 1'b0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         dz_q     <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         b_q      <= b_d;
         a_raw_q  <= a_raw_d;
         is_div_q <= is_div_d;
         neg_q    <= neg_d;
         rneg_q   <= rneg_d;
         dz_q     <= dz_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         done_q   <= done_d;
      end
   end

   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;
   assign bus.busy = (state_q != IDLE);
   assign bus.done = done_q;
   assign dbg_state = state_q;

endmodule
